// File: rtl/serial_subtractor_ctrl_if.sv
// Request/result bundle between a requesting datapath and the bit-serial subtractor.
// The requester drives operands and start; the subtractor returns status and result.
interface serial_subtractor_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b, borrow_in,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b, borrow_in,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell, LSB first, one bit per clock.
// The final borrow and difference are published together with a one-cycle done pulse.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    serial_subtractor_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next, diff_q;
    logic             bc_q, borrow_q;
    logic [CW-1:0]    cnt_q;
    logic             ai, bi, d, bnext;
    logic             accept, last_bit;

    // Full-subtractor cell on the current LSBs and the carried borrow.
    assign ai    = a_sr[0];
    assign bi    = b_sr[0];
    assign d     = ai ^ bi ^ bc_q;
    assign bnext = (~ai & bi) | (~(ai ^ bi) & bc_q);

    assign accept   = bus.start && ((state_q == IDLE) || (state_q == DONE));
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // Result bits enter from the MSB side so bit 0 ends up at position 0.
    always_comb begin
        res_next            = res_sr >> 1;
        res_next[WIDTH-1]   = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: flops are always written with <= so every register samples
            // the pre-edge values, independent of statement order.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch is inferred for state_d.
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = accept ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: operand/result shift registers are reset as well, so a
            // discarded operation leaves no stale bits behind.
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            bc_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            bc_q   <= bus.borrow_in;
            res_sr <= '0;
            cnt_q  <= '0;
        end else if (state_q == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            bc_q   <= bnext;
            res_sr <= res_next;
            cnt_q  <= cnt_q + CW'(1);
            // Publish only on the last bit; partial sums never reach diff.
            if (last_bit) begin
                diff_q   <= res_next;
                borrow_q <= bnext;
            end
        end
    end

    assign bus.busy       = (state_q == SHIFT);
    assign bus.done       = (state_q == DONE);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench for serial_subtractor_ctrl: a WIDTH=8 instance for the main
// scenarios and a WIDTH=1 instance for the single-cell truth table.
module tb_serial_subtractor_ctrl;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    serial_subtractor_ctrl_if #(.WIDTH(8)) if0 ();
    serial_subtractor_ctrl_if #(.WIDTH(1)) if1 ();

    serial_subtractor_ctrl #(.WIDTH(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    serial_subtractor_ctrl #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    typedef struct packed {
        logic [7:0] diff;
        logic       bo;
    } exp8_t;

    typedef struct packed {
        logic d;
        logic bo;
    } exp1_t;

    exp8_t sb8[$];
    exp1_t sb1[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    function automatic exp8_t model8(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] r;
        r = {1'b0, a} - {1'b0, b} - {8'b0, c};
        return '{diff: r[7:0], bo: r[8]};
    endfunction

    function automatic exp1_t model1(input logic a, input logic b, input logic c);
        logic [1:0] r;
        r = {1'b0, a} - {1'b0, b} - {1'b0, c};
        return '{d: r[0], bo: r[1]};
    endfunction

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands, take the accepting edge E0, drop start, record expectation.
    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c);
        if0.a         = a;
        if0.b         = b;
        if0.borrow_in = c;
        if0.start     = 1'b1;
        sb8.push_back(model8(a, b, c));
        step();
        if0.start = 1'b0;
    endtask

    task automatic wait_done8(input int budget, output int edges);
        edges = 0;
        while (if0.done !== 1'b1 && edges < budget) begin
            step();
            edges++;
        end
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (if0.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", if0.busy); end
        n_cmp++; if (if0.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", if0.done); end
        n_cmp++; if (if0.diff !== 8'h00) begin n_bad++; $display("FAIL reset_diff: got %h want 00", if0.diff); end
        n_cmp++; if (if0.borrow_out !== 1'b0) begin n_bad++; $display("FAIL reset_borrow: got %b want 0", if0.borrow_out); end
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        exp8_t      e;
        logic [7:0] prev;
        prev = if0.diff;
        start8(8'h5A, 8'h3C, 1'b0);
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (if0.busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy@%0d: got %b want 1", k, if0.busy); end
            n_cmp++; if (if0.done !== 1'b0) begin n_bad++; $display("FAIL basic_early_done@%0d: got %b want 0", k, if0.done); end
            n_cmp++; if (if0.diff !== prev) begin n_bad++; $display("FAIL basic_partial_diff@%0d: got %h want %h", k, if0.diff, prev); end
            step();
        end
        n_cmp++; if (if0.busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_end: got %b want 0", if0.busy); end
        n_cmp++; if (if0.done !== 1'b1) begin n_bad++; $display("FAIL basic_done: got %b want 1", if0.done); end
        e = sb8.pop_front();
        n_cmp++; if (if0.diff !== e.diff) begin n_bad++; $display("FAIL basic_diff: got %h want %h", if0.diff, e.diff); end
        n_cmp++; if (if0.borrow_out !== e.bo) begin n_bad++; $display("FAIL basic_borrow: got %b want %b", if0.borrow_out, e.bo); end
        step();
        n_cmp++; if (if0.done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse: got %b want 0", if0.done); end
        n_cmp++; if (if0.diff !== e.diff) begin n_bad++; $display("FAIL basic_diff_hold: got %h want %h", if0.diff, e.diff); end
    endtask

    task automatic test_underflow();
        exp8_t e;
        int    edges;
        start8(8'h00, 8'h01, 1'b0);
        wait_done8(20, edges);
        n_cmp++; if (edges !== 8) begin n_bad++; $display("FAIL uflow1_latency: got %0d want 8", edges); end
        e = sb8.pop_front();
        n_cmp++; if (if0.diff !== e.diff) begin n_bad++; $display("FAIL uflow1_diff: got %h want %h", if0.diff, e.diff); end
        n_cmp++; if (if0.borrow_out !== e.bo) begin n_bad++; $display("FAIL uflow1_borrow: got %b want %b", if0.borrow_out, e.bo); end
        step();
        start8(8'hFF, 8'hFF, 1'b1);
        wait_done8(20, edges);
        n_cmp++; if (edges !== 8) begin n_bad++; $display("FAIL uflow2_latency: got %0d want 8", edges); end
        e = sb8.pop_front();
        n_cmp++; if (if0.diff !== e.diff) begin n_bad++; $display("FAIL uflow2_diff: got %h want %h", if0.diff, e.diff); end
        n_cmp++; if (if0.borrow_out !== e.bo) begin n_bad++; $display("FAIL uflow2_borrow: got %b want %b", if0.borrow_out, e.bo); end
        step();
    endtask

    task automatic test_ignored_start();
        exp8_t      e;
        logic [7:0] prev;
        int         edges;
        prev = if0.diff;
        start8(8'h33, 8'h10, 1'b0);
        step(); step(); step();
        if0.start     = 1'b1;
        if0.a         = 8'h11;
        if0.b         = 8'h77;
        if0.borrow_in = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            n_cmp++; if (if0.busy !== 1'b1) begin n_bad++; $display("FAIL ign_busy@%0d: got %b want 1", k, if0.busy); end
            n_cmp++; if (if0.diff !== prev) begin n_bad++; $display("FAIL ign_diff_stable@%0d: got %h want %h", k, if0.diff, prev); end
        end
        if0.start = 1'b0;
        wait_done8(20, edges);
        n_cmp++; if (edges !== 3) begin n_bad++; $display("FAIL ign_latency: got %0d want 3", edges); end
        e = sb8.pop_front();
        n_cmp++; if (if0.diff !== e.diff) begin n_bad++; $display("FAIL ign_diff: got %h want %h", if0.diff, e.diff); end
        n_cmp++; if (if0.borrow_out !== e.bo) begin n_bad++; $display("FAIL ign_borrow: got %b want %b", if0.borrow_out, e.bo); end
        step();
    endtask

    task automatic test_back_to_back();
        exp8_t e;
        int    edges;
        if0.a         = 8'h80;
        if0.b         = 8'h01;
        if0.borrow_in = 1'b0;
        if0.start     = 1'b1;
        sb8.push_back(model8(8'h80, 8'h01, 1'b0));
        step();
        wait_done8(20, edges);
        n_cmp++; if (edges !== 8) begin n_bad++; $display("FAIL b2b_latency1: got %0d want 8", edges); end
        e = sb8.pop_front();
        n_cmp++; if (if0.diff !== e.diff) begin n_bad++; $display("FAIL b2b_diff1: got %h want %h", if0.diff, e.diff); end
        n_cmp++; if (if0.borrow_out !== e.bo) begin n_bad++; $display("FAIL b2b_borrow1: got %b want %b", if0.borrow_out, e.bo); end
        sb8.push_back(model8(8'h80, 8'h01, 1'b0));
        step();
        if0.start = 1'b0;
        n_cmp++; if (if0.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_rebusy: got %b want 1", if0.busy); end
        n_cmp++; if (if0.done !== 1'b0) begin n_bad++; $display("FAIL b2b_done_pulse: got %b want 0", if0.done); end
        wait_done8(20, edges);
        n_cmp++; if (edges + 1 !== 9) begin n_bad++; $display("FAIL b2b_latency2: got %0d want 9", edges + 1); end
        e = sb8.pop_front();
        n_cmp++; if (if0.diff !== e.diff) begin n_bad++; $display("FAIL b2b_diff2: got %h want %h", if0.diff, e.diff); end
        n_cmp++; if (if0.borrow_out !== e.bo) begin n_bad++; $display("FAIL b2b_borrow2: got %b want %b", if0.borrow_out, e.bo); end
        step();
    endtask

    task automatic test_reset_mid_op();
        exp8_t e;
        int    edges;
        int    seen;
        start8(8'hAA, 8'h55, 1'b0);
        step(); step(); step();
        #3;
        rst_n = 1'b0;
        sb8.delete();
        #1;
        n_cmp++; if (if0.busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", if0.busy); end
        n_cmp++; if (if0.done !== 1'b0) begin n_bad++; $display("FAIL rmid_done: got %b want 0", if0.done); end
        n_cmp++; if (if0.diff !== 8'h00) begin n_bad++; $display("FAIL rmid_diff: got %h want 00", if0.diff); end
        n_cmp++; if (if0.borrow_out !== 1'b0) begin n_bad++; $display("FAIL rmid_borrow: got %b want 0", if0.borrow_out); end
        step(); step();
        #2;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (if0.done === 1'b1 || if0.busy === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rmid_ghost_activity: got %0d want 0", seen); end
        start8(8'hC3, 8'h3C, 1'b1);
        wait_done8(20, edges);
        n_cmp++; if (edges !== 8) begin n_bad++; $display("FAIL rmid_latency: got %0d want 8", edges); end
        e = sb8.pop_front();
        n_cmp++; if (if0.diff !== e.diff) begin n_bad++; $display("FAIL rmid_diff_after: got %h want %h", if0.diff, e.diff); end
        n_cmp++; if (if0.borrow_out !== e.bo) begin n_bad++; $display("FAIL rmid_borrow_after: got %b want %b", if0.borrow_out, e.bo); end
        step();
    endtask

    task automatic test_width1();
        exp1_t e;
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v             = 3'(i);
            if1.a         = v[2];
            if1.b         = v[1];
            if1.borrow_in = v[0];
            if1.start     = 1'b1;
            sb1.push_back(model1(v[2], v[1], v[0]));
            step();
            if1.start = 1'b0;
            n_cmp++; if (if1.busy !== 1'b1) begin n_bad++; $display("FAIL w1_busy[%0d]: got %b want 1", i, if1.busy); end
            step();
            n_cmp++; if (if1.done !== 1'b1) begin n_bad++; $display("FAIL w1_done[%0d]: got %b want 1", i, if1.done); end
            e = sb1.pop_front();
            n_cmp++; if (if1.diff !== e.d) begin n_bad++; $display("FAIL w1_diff[%0d]: got %b want %b", i, if1.diff, e.d); end
            n_cmp++; if (if1.borrow_out !== e.bo) begin n_bad++; $display("FAIL w1_borrow[%0d]: got %b want %b", i, if1.borrow_out, e.bo); end
            step();
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        if0.start     = 1'b0;
        if0.a         = '0;
        if0.b         = '0;
        if0.borrow_in = 1'b0;
        if1.start     = 1'b0;
        if1.a         = '0;
        if1.b         = '0;
        if1.borrow_in = 1'b0;
        test_reset();
        test_basic();
        test_underflow();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_op();
        test_width1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
- Bit-serial multi-bit subtractor built around a single 1-bit full-subtractor cell.
- Latches two WIDTH-bit operands on a start handshake, then feeds the cell LSB-first, one bit per clock.
- Carries the borrow bit-to-bit in a flop and returns the registered difference and final borrow with a done pulse.
- Area-cheap alternative to a ripple array; sits between a requesting datapath and the shared subtractor cell.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  minuend; sampled on accepted start.
- b  input  WIDTH  subtrahend; sampled on accepted start.
- borrow_in  input  1  initial borrow; sampled on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  registered result.
- borrow_out  output  1  registered final borrow.

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE, busy=0, done=0, diff=0, borrow_out=0. Internal operand shift registers, borrow flop and bit counter are cleared. An in-flight operation is discarded with no done pulse.
- Cell equations, combinational, per bit:
  - d = ai ^ bi ^ bc
  - bnext = (~ai & bi) | (~(ai ^ bi) & bc)
- Arithmetic result: diff = (a - b - borrow_in) mod 2^WIDTH; borrow_out = 1 iff a < b + borrow_in (unsigned).
- FSM states and transitions:
  - IDLE: start=1 at edge E0 → latch a, b, borrow_in into the borrow flop; counter=0; go to SHIFT. start=0 → stay.
  - SHIFT: busy=1. At each edge, process the bit at the shift-register LSB. Shift the result bit into the result register from the MSB side, update the borrow flop, increment the counter. At the edge that processes bit WIDTH-1, go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle.
    - start=1 → accept the new operands exactly as in IDLE and go to SHIFT (back-to-back, no bubble).
    - start=0 → go to IDLE.
- Timing:
  - Bit i is processed at edge E(i+1); busy is high for exactly WIDTH cycles (E0..E(WIDTH)).
  - diff and borrow_out update only at edge E(WIDTH); done is high between E(WIDTH) and E(WIDTH+1).
  - Total latency is WIDTH+1 edges from start to done.
- Outputs: diff and borrow_out hold their value until the next completion or reset. Partial results never appear on diff.
- start while busy: ignored; operands are not re-sampled.
- Counter: log2(WIDTH)+1 bits; compares against WIDTH-1, no wrap-around. WIDTH=1 gives one SHIFT cycle.
- a, b and borrow_in may change freely after the accepting edge.

Test Plan (WIDTH=8 unless stated):
- Basic: reset, then a=0x5A, b=0x3C, borrow_in=0, start pulse at E0 → busy high 8 cycles; done at E8..E9; diff=0x1E, borrow_out=0.
- Underflow: a=0x00, b=0x01, borrow_in=0 → diff=0xFF, borrow_out=1. Second operation: a=0xFF, b=0xFF, borrow_in=1 → diff=0xFF, borrow_out=1.
- Ignored start and stability: assert start again mid-SHIFT with a=0x11 and change a/b → result is still from the original operands, and diff is unchanged until done.
- Back-to-back: hold start high through DONE with a=0x80, b=0x01 → done pulse, then busy re-asserts next cycle; second diff=0x7F, borrow_out=0, done again 9 edges later.
- Reset mid-op: drop rst_n asynchronously (between edges) during SHIFT bit 3 → busy, done, diff and borrow_out are 0 immediately; no done pulse after release; the next start completes normally.
- WIDTH=1 sweep of all 8 input combinations (a, b, borrow_in) → diff and borrow_out match the cell truth table; done two edges after start.
